gray_window_buffer: RTL and testbench

Downstream neighbour of the `grayscale` stage in the Sobel edge-detection pipeline. Accepts one 8-bit gray pixel per `gray_done` pulse in raster order and keeps the two previous image rows in line buffers. For every pixel position whose full 3x3 neighbourhood lies inside the image, it presents that neighbourhood as a 9-pixel window to the Sobel gradient stage. It has no backpressure: the consumer takes every window on the cycle it is valid.

---
 rtl/sobel_pkg.sv | 22 ++
 rtl/gray_line_buffer.sv | 26 ++
 rtl/gray_window_buffer.sv | 133 +++++++++++++
 tb/tb_gray_window_buffer.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/sobel_pkg.sv
// Shared types for the Sobel pipeline: pixels, 3x3 windows and window-buffer states.
package sobel_pkg;

  typedef logic [7:0] pixel_t;
  typedef pixel_t [8:0] window_t;

  typedef enum logic [1:0] {
    IDLE,
    PRIME,
    STREAM
  } win_state_t;

  localparam int WIN_DIM    = 3;
  localparam int WIN_CENTER = 4;
  localparam int WIN_SIZE   = 9;

  // Row-major window index, r=0 oldest row, c=0 leftmost column.
  function automatic int win_idx(input int r, input int c);
    return WIN_DIM * r + c;
  endfunction

endpackage

// File: rtl/gray_line_buffer.sv
// One image row of pixels; read is combinational at addr_i so the old value is seen
// in the same cycle the new one is written (read-before-write). No reset on the store.
module gray_line_buffer
  import sobel_pkg::*;
#(
  parameter int DEPTH = 640,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          wr_en_i,
  input  logic [AW-1:0] addr_i,
  input  pixel_t        wr_data_i,
  output pixel_t        rd_data_o
);

  pixel_t mem_q [DEPTH];

  assign rd_data_o = mem_q[addr_i];

  always_ff @(posedge clk) begin
    if (wr_en_i) begin
      mem_q[addr_i] <= wr_data_i;
    end
  end

endmodule

// File: rtl/gray_window_buffer.sv
// Raster gray pixels in, 3x3 windows out one cycle after each accept that completes
// a fully in-image neighbourhood; no backpressure, consumer takes every window.
module gray_window_buffer
  import sobel_pkg::*;
#(
  parameter int IMG_WIDTH  = 640,
  parameter int IMG_HEIGHT = 480
) (
  input  logic    clk,
  input  logic    n_rst,
  input  logic    frame_start,
  input  pixel_t  gray_pixel,
  input  logic    gray_done,
  output window_t window,
  output logic    window_valid,
  output logic    frame_done
);

  localparam int CW = $clog2(IMG_WIDTH);
  localparam int RW = $clog2(IMG_HEIGHT);
  localparam logic [CW-1:0] COL_LAST = CW'(IMG_WIDTH - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(IMG_HEIGHT - 1);
  localparam logic [CW-1:0] COL_TWO  = CW'(2);
  localparam logic [RW-1:0] ROW_ONE  = RW'(1);
  localparam logic [RW-1:0] ROW_TWO  = RW'(2);

  win_state_t    state_q, state_d;
  logic [CW-1:0] col_q, col_d;
  logic [RW-1:0] row_q, row_d;
  window_t       win_q, win_d;
  logic          valid_q, valid_d;
  logic          done_q, done_d;

  logic          accept;
  pixel_t        old_rd, new_rd;
  pixel_t [2:0]  new_col;

  // frame_start has priority: a coincident pixel is dropped.
  assign accept  = gray_done && !frame_start && (state_q != IDLE);
  assign new_col = {gray_pixel, new_rd, old_rd};

  gray_line_buffer #(
    .DEPTH (IMG_WIDTH),
    .AW    (CW)
  ) u_lb_old (
    .clk       (clk),
    .wr_en_i   (accept),
    .addr_i    (col_q),
    .wr_data_i (new_rd),
    .rd_data_o (old_rd)
  );

  gray_line_buffer #(
    .DEPTH (IMG_WIDTH),
    .AW    (CW)
  ) u_lb_new (
    .clk       (clk),
    .wr_en_i   (accept),
    .addr_i    (col_q),
    .wr_data_i (gray_pixel),
    .rd_data_o (new_rd)
  );

  always_comb begin
    state_d = state_q;
    col_d   = col_q;
    row_d   = row_q;
    win_d   = win_q;
    valid_d = 1'b0;
    done_d  = 1'b0;

    if (frame_start) begin
      state_d = PRIME;
      col_d   = '0;
      row_d   = '0;
    end else if (accept) begin
      for (int r = 0; r < WIN_DIM; r++) begin
        win_d[win_idx(r, 0)] = win_q[win_idx(r, 1)];
        win_d[win_idx(r, 1)] = win_q[win_idx(r, 2)];
        win_d[win_idx(r, 2)] = new_col[r];
      end

      // Windows at columns 0 and 1 straddle the row wrap and are never flagged.
      valid_d = (row_q >= ROW_TWO) && (col_q >= COL_TWO);

      if (col_q == COL_LAST) begin
        col_d = '0;
        row_d = row_q + RW'(1);
      end else begin
        col_d = col_q + CW'(1);
      end

      case (state_q)
        PRIME: begin
          if ((col_q == COL_LAST) && (row_q == ROW_ONE)) begin
            state_d = STREAM;
          end
        end
        STREAM: begin
          if ((col_q == COL_LAST) && (row_q == ROW_LAST)) begin
            state_d = IDLE;
            row_d   = '0;
            done_d  = 1'b1;
          end
        end
        default: state_d = state_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q <= IDLE;
      col_q   <= '0;
      row_q   <= '0;
      win_q   <= '0;
      valid_q <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      col_q   <= col_d;
      row_q   <= row_d;
      win_q   <= win_d;
      valid_q <= valid_d;
      done_q  <= done_d;
    end
  end

  assign window       = win_q;
  assign window_valid = valid_q;
  assign frame_done   = done_q;

endmodule

// File: tb/tb_gray_window_buffer.sv
// Two instances (4x4 and 5x4) share one random/directed input stream; an image-array
// model per instance predicts valid, frame_done and window contents every cycle.
module tb_gray_window_buffer;
  import sobel_pkg::*;

  logic    clk = 1'b0;
  logic    n_rst = 1'b0;
  logic    frame_start = 1'b0;
  logic    gray_done = 1'b0;
  pixel_t  gray_pixel = '0;

  window_t win_a, win_b;
  logic    va, vb, da, db;

  always #5 clk = ~clk;

  gray_window_buffer #(.IMG_WIDTH(4), .IMG_HEIGHT(4)) dut_a (
    .clk          (clk),
    .n_rst        (n_rst),
    .frame_start  (frame_start),
    .gray_pixel   (gray_pixel),
    .gray_done    (gray_done),
    .window       (win_a),
    .window_valid (va),
    .frame_done   (da)
  );

  gray_window_buffer #(.IMG_WIDTH(5), .IMG_HEIGHT(4)) dut_b (
    .clk          (clk),
    .n_rst        (n_rst),
    .frame_start  (frame_start),
    .gray_pixel   (gray_pixel),
    .gray_done    (gray_done),
    .window       (win_b),
    .window_valid (vb),
    .frame_done   (db)
  );

  int n_checks = 0;
  int n_err    = 0;

  // Model state: image contents seen so far in the current frame, per instance.
  bit      armed [2] = '{0, 0};
  int      npx   [2] = '{0, 0};
  logic    ev    [2] = '{1'b0, 1'b0};
  logic    ed    [2] = '{1'b0, 1'b0};
  window_t ew    [2];
  pixel_t  img   [2][4][8];

  window_t log_a[$];
  window_t log_b[$];
  logic    dlog_a[$];
  int      cnt [2] = '{0, 0};

  task automatic check(input string name, input logic [71:0] act, input logic [71:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic cmp_one(input int k, input logic v, input logic d, input window_t w);
    check($sformatf("valid%0d", k), {71'd0, v}, {71'd0, ev[k]});
    check($sformatf("done%0d", k), {71'd0, d}, {71'd0, ed[k]});
    if (ev[k] === 1'b1) check($sformatf("window%0d", k), w, ew[k]);
    if (v === 1'b1) begin
      cnt[k]++;
      if (k == 0) begin
        log_a.push_back(w);
        dlog_a.push_back(d);
      end else begin
        log_b.push_back(w);
      end
    end
  endtask

  function automatic window_t at_a(input int i);
    window_t x;
    x = 'x;
    if (i >= 0 && i < log_a.size()) x = log_a[i];
    return x;
  endfunction

  function automatic window_t at_b(input int i);
    window_t x;
    x = 'x;
    if (i >= 0 && i < log_b.size()) x = log_b[i];
    return x;
  endfunction

  task automatic cyc(input logic fs, input logic gd, input pixel_t p);
    @(negedge clk);
    frame_start = fs;
    gray_done   = gd;
    gray_pixel  = p;
  endtask

  task automatic frame_pat(input int w, input pixel_t base, input int gap);
    cyc(1'b1, 1'b0, '0);
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < w; c++) begin
        repeat (gap) cyc(1'b0, 1'b0, pixel_t'($urandom));
        cyc(1'b0, 1'b1, base + pixel_t'(16 * r + c));
      end
    end
    repeat (4) cyc(1'b0, 1'b0, '0);
  endtask

  localparam window_t FIRST_W4 = {8'h22, 8'h21, 8'h20, 8'h12, 8'h11, 8'h10, 8'h02, 8'h01, 8'h00};
  localparam window_t LAST_W4  = {8'h33, 8'h32, 8'h31, 8'h23, 8'h22, 8'h21, 8'h13, 8'h12, 8'h11};
  localparam window_t W5_R3C2  = {8'h32, 8'h31, 8'h30, 8'h22, 8'h21, 8'h20, 8'h12, 8'h11, 8'h10};

  initial begin
    int ca0, cb0;
    pixel_t minb;
    logic   nib_ok;

    fork
      forever begin
        @(posedge clk or negedge n_rst);
        for (int k = 0; k < 2; k++) begin
          int w, r, c;
          w = (k == 0) ? 4 : 5;
          ev[k] = 1'b0;
          ed[k] = 1'b0;
          if (!n_rst) begin
            armed[k] = 0;
          end else if (frame_start) begin
            armed[k] = 1;
            npx[k]   = 0;
          end else if (gray_done && armed[k]) begin
            r = npx[k] / w;
            c = npx[k] % w;
            img[k][r][c] = gray_pixel;
            npx[k]++;
            if (r >= 2 && c >= 2) begin
              ev[k] = 1'b1;
              for (int i = 0; i < 3; i++)
                for (int j = 0; j < 3; j++)
                  ew[k][3 * i + j] = img[k][r - 2 + i][c - 2 + j];
            end
            if (npx[k] == w * 4) begin
              ed[k]    = 1'b1;
              armed[k] = 0;
            end
          end
        end
      end
      forever begin
        @(negedge clk);
        cmp_one(0, va, da, win_a);
        cmp_one(1, vb, db, win_b);
      end
    join_none

    // Reset values, then pixels before any frame_start are ignored.
    #3;
    check("rst_window", win_a, '0);
    check("rst_valid", {71'd0, va}, 72'd0);
    check("rst_done", {71'd0, da}, 72'd0);
    repeat (2) @(negedge clk);
    n_rst = 1'b1;
    ca0 = cnt[0];
    repeat (6) cyc(1'b0, 1'b1, pixel_t'($urandom));
    repeat (2) cyc(1'b0, 1'b0, '0);
    check("no_frame_count", cnt[0] - ca0, 0);

    // Back-to-back frame.
    ca0 = cnt[0];
    frame_pat(4, 8'h00, 0);
    check("b2b_count", cnt[0] - ca0, 4);
    check("b2b_first", at_a(ca0), FIRST_W4);
    check("b2b_last", at_a(ca0 + 3), LAST_W4);
    check("b2b_last_done", {71'd0, (dlog_a.size() > ca0 + 3) ? dlog_a[ca0 + 3] : 1'bx}, 72'd1);

    // Gapped input: gray_done every third cycle.
    ca0 = cnt[0];
    frame_pat(4, 8'h00, 2);
    check("gap_count", cnt[0] - ca0, 4);
    check("gap_first", at_a(ca0), FIRST_W4);
    check("gap_last", at_a(ca0 + 3), LAST_W4);

    // Row wrap on the 5-wide instance.
    cb0 = cnt[1];
    frame_pat(5, 8'h00, 0);
    check("wrap_count", cnt[1] - cb0, 6);
    check("wrap_r3c2", at_b(cb0 + 3), W5_R3C2);

    // Abort after 10 pixels, then a fresh frame.
    cyc(1'b1, 1'b0, '0);
    for (int i = 0; i < 10; i++) cyc(1'b0, 1'b1, pixel_t'(16 * (i / 4) + i % 4));
    ca0 = cnt[0];
    frame_pat(4, 8'h80, 0);
    check("abort_count", cnt[0] - ca0, 4);
    minb = 8'hff;
    for (int i = 0; i < 4; i++) begin
      window_t ww;
      ww = at_a(ca0 + i);
      for (int j = 0; j < 9; j++) if (ww[j] < minb) minb = ww[j];
    end
    check("abort_min", {71'd0, minb >= 8'h80}, 72'd1);
    nib_ok = 1'b1;
    for (int j = 0; j < 9; j++) begin
      window_t w0;
      w0 = at_a(ca0);
      if (w0[j][7:4] == 4'h0) nib_ok = 1'b0;
    end
    check("abort_first_fresh", {71'd0, nib_ok}, 72'd1);

    // Coincident frame_start/gray_done, then randomized traffic with random aborts.
    cyc(1'b1, 1'b1, 8'hee);
    for (int i = 0; i < 600; i++)
      cyc(($urandom % 30) == 0, ($urandom % 3) != 0, pixel_t'($urandom));
    repeat (3) cyc(1'b0, 1'b0, '0);

    // Async reset between edges while window_valid is high.
    cyc(1'b1, 1'b0, '0);
    for (int i = 0; i < 11; i++) cyc(1'b0, 1'b1, pixel_t'(16 * (i / 4) + i % 4));
    @(posedge clk);
    #1;
    check("pre_reset_valid", {71'd0, va}, 72'd1);
    #1 n_rst = 1'b0;
    #1;
    check("async_valid", {71'd0, va}, 72'd0);
    check("async_window", win_a, '0);
    check("async_done", {71'd0, da}, 72'd0);
    repeat (2) cyc(1'b0, 1'b1, pixel_t'($urandom));
    @(negedge clk);
    n_rst = 1'b1;
    ca0 = cnt[0];
    repeat (8) cyc(1'b0, 1'b1, pixel_t'($urandom));
    repeat (2) cyc(1'b0, 1'b0, '0);
    check("post_reset_count", cnt[0] - ca0, 0);
    ca0 = cnt[0];
    frame_pat(4, 8'h00, 0);
    check("refill_count", cnt[0] - ca0, 4);
    check("refill_first", at_a(ca0), FIRST_W4);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
